div_32: RTL

DIV_32 -- requirements
Module: div_32

---
 rtl/div_32_pkg.sv | 8 +
 rtl/add_sub_32.sv | 13 +
 rtl/div_32.sv | 83 ++++++++
 3 files changed

// File: rtl/div_32_pkg.sv
// div_32_pkg: shared FSM encoding, default width and counter sizing for div_32
package div_32_pkg;
  localparam int DEF_N = 32;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/add_sub_32.sv
// add_sub_32: W-bit adder/subtractor; sel=1 gives a-b, cout is then not-borrow
// ports: a, b operands; sel 0=add 1=subtract; sum W-bit result; cout carry out
module add_sub_32 #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel,
  output logic [W-1:0] sum,
  output logic         cout
);
  always_comb {cout, sum} = {1'b0, a} + {1'b0, b ^ {W{sel}}} + {{W{1'b0}}, sel};
endmodule

// File: rtl/div_32.sv
// div_32: sequential restoring divider, signed/unsigned, one quotient bit per cycle
// ports: clk, rst_n (async active-low); start/sgn/dividend/divisor request a division;
//        busy while iterating; done one-cycle pulse with quotient/remainder/div_zero valid
module div_32
  import div_32_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sgn,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_zero
);
  localparam int CW = cnt_w(N);
  state_t state;
  logic [N-1:0] rem, dq, dvsr, rem_n, q_n;
  logic [CW-1:0] cnt;
  logic [N:0] diff;
  logic neg_q, neg_r, nb, accept, last, unused_hi;
  // one negation path serves both operand magnitudes and final sign correction
  function automatic logic [N-1:0] cond_neg(input logic [N-1:0] v, input logic c);
    return c ? -v : v;
  endfunction
  // dq shifts dividend bits out at the top while quotient bits enter at the bottom
  add_sub_32 #(.W(N + 1)) u_trial (
    .a    ({rem, dq[N-1]}),
    .b    ({1'b0, dvsr}),
    .sel  (1'b1),
    .sum  (diff),
    .cout (nb)
  );
  always_comb begin
    rem_n = nb ? diff[N-1:0] : {rem[N-2:0], dq[N-1]};
    q_n   = {dq[N-2:0], nb};
  end
  assign unused_hi = diff[N];
  assign accept    = start && state != BUSY;
  assign last      = cnt == CW'(N - 1);
  assign busy      = state == BUSY;
  assign done      = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      rem       <= '0;
      dq        <= '0;
      dvsr      <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else if (accept) begin
      state    <= divisor == '0 ? DONE : BUSY;
      div_zero <= divisor == '0;
      neg_q    <= sgn && (dividend[N-1] ^ divisor[N-1]);
      neg_r    <= sgn && dividend[N-1];
      rem      <= '0;
      dq       <= cond_neg(dividend, sgn && dividend[N-1]);
      dvsr     <= cond_neg(divisor, sgn && divisor[N-1]);
      cnt      <= '0;
      if (divisor == '0) begin
        quotient  <= '1;
        remainder <= dividend;
      end
    end else if (state == BUSY) begin
      rem <= rem_n;
      dq  <= q_n;
      cnt <= cnt + 1'b1;
      if (last) begin
        state     <= DONE;
        quotient  <= cond_neg(q_n, neg_q);
        remainder <= cond_neg(rem_n, neg_r);
      end
    end else if (state == DONE) state <= IDLE;
endmodule
